// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
//
// Multiplexed 7-segment display controller. NUM_GROUPS banks of
// DIGITS_PER_GROUP digits are scanned in lockstep, one digit per bank per scan
// slot. The frame (digit nibbles plus per-digit enable, blink and decimal-point
// masks) is captured into shadow registers on a load strobe. The display always
// runs from the shadow copy, so a frame that is only half updated is never
// shown.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   load           single-cycle strobe, captures data_i/en_i/blink_i/dp_i
//   data_i         4 bits per digit, digit k at [4k+3:4k], digit 0 = group 0 slot 0
//   en_i           per-digit display enable
//   blink_i        per-digit blink mask
//   dp_i           per-digit decimal point
//   blink_restart  strobe that restarts the blink phase in its visible half
//   led_cx_o       8 segment bits per group (bit0=a .. bit6=g, bit7=dp), active-high
//   led_en_o       digit enables, active-high, at most one set per group
//   frame_start    one-cycle pulse on the first cycle after scan slot 0 begins
// -----------------------------------------------------------------------------
module seg_scan_display #(
  parameter int NUM_GROUPS       = 2,
  parameter int DIGITS_PER_GROUP = 4,
  parameter int SCAN_DIV         = 100000,
  parameter int BLINK_DIV        = 12500000
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     load,
  input  logic [4*NUM_GROUPS*DIGITS_PER_GROUP-1:0] data_i,
  input  logic [NUM_GROUPS*DIGITS_PER_GROUP-1:0]   en_i,
  input  logic [NUM_GROUPS*DIGITS_PER_GROUP-1:0]   blink_i,
  input  logic [NUM_GROUPS*DIGITS_PER_GROUP-1:0]   dp_i,
  input  logic                                     blink_restart,
  output logic [8*NUM_GROUPS-1:0]                  led_cx_o,
  output logic [NUM_GROUPS*DIGITS_PER_GROUP-1:0]   led_en_o,
  output logic                                     frame_start
);

  localparam int N    = NUM_GROUPS * DIGITS_PER_GROUP;
  localparam int SCW  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDXW = $clog2(DIGITS_PER_GROUP);

  localparam logic [SCW-1:0]  SCAN_LAST  = SCW'(SCAN_DIV - 1);
  localparam logic [BLW-1:0]  BLINK_LAST = BLW'(BLINK_DIV - 1);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(DIGITS_PER_GROUP - 1);

  // Shadow copy of the frame; the outputs only ever look at these.
  logic [4*N-1:0]  data_q;
  logic [N-1:0]    en_q;
  logic [N-1:0]    blink_q;
  logic [N-1:0]    dp_q;

  logic [SCW-1:0]  scan_cnt;
  logic [IDXW-1:0] scan_idx;
  logic [BLW-1:0]  blink_cnt;
  logic            blink_phase;   // 1 = visible half of the blink period

  logic [8*NUM_GROUPS-1:0] cx_d;
  logic [N-1:0]            en_d;

  // Hex digit to segments, bit order gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    unique case (v)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // Next output pattern: every group shows its digit at the shared scan slot.
  always_comb begin
    int  k;
    logic vis;
    // NOTE: every output of this block gets a default before any branch, so
    // no path can leave a value unassigned and infer a latch.
    cx_d = '0;
    en_d = '0;
    k    = 0;
    vis  = 1'b0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      k   = g * DIGITS_PER_GROUP + int'(scan_idx);
      // A blinking digit is hidden during the dark half of the blink period.
      vis = en_q[k] & ~(blink_q[k] & ~blink_phase);
      en_d[k] = vis;
      if (vis) begin
        cx_d[8*g +: 7] = hex_to_seg(data_q[4*k +: 4]);
        cx_d[8*g + 7]  = dp_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    if (rst) begin
      // The shadow frame is cleared too, so the display comes up dark.
      data_q      <= '0;
      en_q        <= '0;
      blink_q     <= '0;
      dp_q        <= '0;
      scan_cnt    <= '0;
      scan_idx    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      led_cx_o    <= '0;
      led_en_o    <= '0;
      frame_start <= 1'b0;
    end else begin
      if (load) begin
        data_q  <= data_i;
        en_q    <= en_i;
        blink_q <= blink_i;
        dp_q    <= dp_i;
      end

      // Scan divider and slot index; loads never touch these.
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      frame_start <= (scan_cnt == SCAN_LAST) && (scan_idx == IDX_LAST);

      // Blink divider; a restart beats a coincident wrap.
      if (blink_restart) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      led_cx_o <= cx_d;
      led_en_o <= en_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_display
//
// Scoreboard bench for seg_scan_display with a short scan and blink period.
// The driver applies one set of inputs per clock, predicts the outputs the
// following edge will produce from an arithmetic model (slot and blink phase
// derived from elapsed cycle counts), and queues that prediction. A monitor
// pops one prediction shortly after each rising edge and compares.
// -----------------------------------------------------------------------------
module tb_seg_scan_display;

  localparam int NG  = 2;
  localparam int DPG = 4;
  localparam int N   = NG * DPG;
  localparam int SD  = 4;
  localparam int BD  = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               load = 1'b0;
  logic [4*N-1:0]     data_i = '0;
  logic [N-1:0]       en_i = '0;
  logic [N-1:0]       blink_i = '0;
  logic [N-1:0]       dp_i = '0;
  logic               blink_restart = 1'b0;
  logic [8*NG-1:0]    led_cx_o;
  logic [N-1:0]       led_en_o;
  logic               frame_start;

  seg_scan_display #(
    .NUM_GROUPS(NG), .DIGITS_PER_GROUP(DPG), .SCAN_DIV(SD), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .data_i(data_i), .en_i(en_i),
    .blink_i(blink_i), .dp_i(dp_i), .blink_restart(blink_restart),
    .led_cx_o(led_cx_o), .led_en_o(led_en_o), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8*NG-1:0] cx;
    logic [N-1:0]    en;
    logic            fs;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model state: cycles since reset, cycles since blink restart,
  // and the captured frame.
  int             m_cyc = 0;
  int             m_blk = 0;
  logic [4*N-1:0] m_data = '0;
  logic [N-1:0]   m_en = '0;
  logic [N-1:0]   m_bl = '0;
  logic [N-1:0]   m_dp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[v];
  endfunction

  function automatic bit model_bright();
    return ((m_blk / BD) % 2) == 0;
  endfunction

  // Outputs produced by the next edge, from the model state before that edge.
  function automatic exp_t predict(input logic rst_in);
    exp_t e;
    int   slot;
    int   k;
    bit   vis;
    e = '0;
    if (!rst_in) begin
      slot = (m_cyc / SD) % DPG;
      for (int g = 0; g < NG; g++) begin
        k   = g * DPG + slot;
        vis = m_en[k] && !(m_bl[k] && !model_bright());
        if (vis) begin
          e.en[k]          = 1'b1;
          e.cx[8*g +: 7]   = seg_of(m_data[4*k +: 4]);
          e.cx[8*g + 7]    = m_dp[k];
        end
      end
      e.fs = ((m_cyc + 1) % (SD * DPG)) == 0;
    end
    return e;
  endfunction

  task automatic drive(input logic r, input logic ld, input logic [4*N-1:0] d,
                       input logic [N-1:0] en, input logic [N-1:0] bl,
                       input logic [N-1:0] dp, input logic rs);
    @(negedge clk);
    rst = r; load = ld; data_i = d; en_i = en; blink_i = bl; dp_i = dp;
    blink_restart = rs;
    exp_q.push_back(predict(r));
    if (r) begin
      m_cyc = 0; m_blk = 0;
      m_data = '0; m_en = '0; m_bl = '0; m_dp = '0;
    end else begin
      if (ld) begin
        m_data = d; m_en = en; m_bl = bl; m_dp = dp;
      end
      m_cyc++;
      m_blk = rs ? 0 : m_blk + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, data_i, en_i, blink_i, dp_i, 1'b0);
  endtask

  // Monitor: one prediction per rising edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("led_cx_o",    32'(led_cx_o),    32'(e.cx));
        check("led_en_o",    32'(led_en_o),    32'(e.en));
        check("frame_start", 32'(frame_start), 32'(e.fs));
      end
    end
  end

  initial begin
    int guard;
    // 1. reset, then run dark with frame_start pulses
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
    idle(40);
    // 2. hex pattern, all enabled
    drive(1'b0, 1'b1, 32'h7654_3210, 8'hFF, 8'h00, 8'h00, 1'b0);
    idle(20);
    // 3. low three digits of group 0 disabled
    drive(1'b0, 1'b1, 32'h0, 8'hF8, 8'h00, 8'h00, 1'b0);
    idle(20);
    // 4. all blinking; restart during a dark half
    drive(1'b0, 1'b1, 32'h0, 8'hFF, 8'hFF, 8'h00, 1'b0);
    idle(40);
    guard = 0;
    while (model_bright() && guard < 2 * BD) begin
      idle(1);
      guard++;
    end
    drive(1'b0, 1'b0, data_i, en_i, blink_i, dp_i, 1'b1);
    idle(20);
    // 5. unloaded data changes, load colliding with reset, decimal point
    drive(1'b0, 1'b1, 32'h89AB_CDEF, 8'hFF, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, $urandom, 8'hFF, 8'h00, 8'hFF, 1'b0);
    drive(1'b1, 1'b1, 32'h1111_1111, 8'hFF, 8'h00, 8'hFF, 1'b0);
    idle(8);
    drive(1'b0, 1'b1, 32'h0, 8'hFF, 8'h00, 8'h01, 1'b0);
    idle(20);
    // 6. load in the middle of a slot
    guard = 0;
    while ((m_cyc % SD) != 2 && guard < SD) begin
      idle(1);
      guard++;
    end
    drive(1'b0, 1'b1, 32'hFEDC_BA98, 8'hA5, 8'h0F, 8'h3C, 1'b0);
    idle(40);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 249) == 0), ($urandom_range(0, 7) == 0), $urandom,
            8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 31) == 0));
    end
    idle(2);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
